// File: rtl/rotate_restore_seq.sv
// Bit-serial inverse rotator: undoes an AMT-place rotation in direction DIR,
// one place per clock, under a start/busy/done handshake.
module rotate_restore_seq #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic          dir,
  input  logic [AW-1:0] amt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  dout_reg, dout_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          dir_reg, dir_next;

  logic [N-1:0]  rotl_w;
  logic [N-1:0]  rotr_w;

  // One-place rotations of the working register in both directions.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rotl_w[gi] = dout_reg[(gi + N - 1) % N];
    assign rotr_w[gi] = dout_reg[(gi + 1) % N];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= S_IDLE;
      dout_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          dout_next  = din;
          cnt_next   = amt;
          dir_next   = dir;
          state_next = (amt != '0) ? S_ROT : S_DONE;
        end
      end
      S_ROT: begin
        // Rotate opposite to the original direction; cnt is never 0 here.
        dout_next = dir_reg ? rotl_w : rotr_w;
        cnt_next  = cnt_reg - AW'(1);
        if (cnt_reg == AW'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state_reg == S_ROT);
  assign done = (state_reg == S_DONE);
  assign dout = dout_reg;

endmodule

// File: tb/tb_rotate_restore_seq.sv
// Randomised and directed bench for rotate_restore_seq, checked every cycle
// against a timeline model of the restore operation.
module tb_rotate_restore_seq;
  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  din = '0;
  logic          dir = 1'b0;
  logic [AW-1:0] amt = '0;
  logic          busy, done;
  logic [N-1:0]  dout;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  rotate_restore_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .din(din), .dir(dir),
    .amt(amt), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rotl(logic [N-1:0] v, int k);
    logic [2*N-1:0] t;
    t = {v, v} << k;
    return t[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] rotr(logic [N-1:0] v, int k);
    return rotl(v, N - k);
  endfunction

  // Word after j restoring steps: undo a right rotation by going left, and vice versa.
  function automatic logic [N-1:0] restore(logic [N-1:0] v, logic d, int j);
    return d ? rotl(v, j) : rotr(v, j);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: remaining rotations, done flag, expected word.
  int           m_rem = 0;
  bit           m_done = 1'b0;
  logic [N-1:0] m_dout = '0;
  logic [N-1:0] m_din = '0;
  logic         m_dir = 1'b0;
  int           m_amt = 0;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_rem = 0; m_done = 1'b0; m_dout = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_dout = restore(m_din, m_dir, m_amt - m_rem);
      if (m_rem == 0) m_done = 1'b1;
    end else if (start) begin
      m_din = din; m_dir = dir; m_amt = int'(amt); m_dout = din;
      if (amt == '0) m_done = 1'b1;
      else m_rem = int'(amt);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", 32'(busy), 32'(m_rem > 0));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_dout", 32'(dout), 32'(m_dout));
    end
  end

  logic [N-1:0] trace [$];

  // Pulse start, wait (bounded) for done, check latency and result.
  task automatic do_op(logic [N-1:0] d, logic r, int a, logic [N-1:0] exp, string tag);
    int lat;
    trace.delete();
    @(negedge clk);
    start = 1'b1; din = d; dir = r; amt = AW'(a);
    @(negedge clk);
    start = 1'b0; din = N'($urandom); dir = 1'($urandom); amt = AW'($urandom);
    lat = 1;
    if (a != 0) chk({tag, "_busy1"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      trace.push_back(dout);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(a + 1));
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    $display("op %s din=%b dir=%0d amt=%0d -> dout=%b latency=%0d", tag, d, r, a, dout, lat);
  endtask

  initial begin
    logic [N-1:0] rd;
    logic         rr;
    int           ra;

    #1 n_reset = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    n_reset = 1'b1;

    do_op(8'b01010110, 1'b1, 1, 8'b10101100, "right1");
    do_op(8'b10010101, 1'b1, 3, 8'b10101100, "right3");
    if (trace.size() == 3) begin
      chk("right3_step1", 32'(trace[0]), 32'(8'b00101011));
      chk("right3_step2", 32'(trace[1]), 32'(8'b01010110));
    end else begin
      chk("right3_trace_len", 32'(trace.size()), 32'd3);
    end
    do_op(8'b10110010, 1'b0, 2, 8'b10101100, "left2");
    do_op(8'b01010110, 1'b0, 7, 8'b10101100, "left7");
    do_op(8'b11110000, 1'b0, 0, 8'b11110000, "zero");
    chk("zero_pin_model", 32'(restore(8'b11110000, 1'b1, 0)), 32'(8'b11110000));

    // START held high with DIN changed mid-rotation.
    @(negedge clk);
    start = 1'b1; din = 8'b10010101; dir = 1'b1; amt = AW'(3);
    @(negedge clk);
    @(negedge clk);
    din = 8'h00; amt = AW'(0);
    begin
      int lat = 2;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk("held_latency", 32'(lat), 32'd4);
    end
    chk("held_dout", 32'(dout), 32'(8'b10101100));
    @(negedge clk);
    chk("held_idle_done", 32'(done), 32'd0);
    chk("held_idle_busy", 32'(busy), 32'd0);
    chk("held_idle_dout", 32'(dout), 32'(8'b10101100));
    @(negedge clk);
    start = 1'b0;
    chk("held_second_done", 32'(done), 32'd1);
    chk("held_second_dout", 32'(dout), 32'd0);
    $display("op held din=10010101 dir=1 amt=3 then din=00000000 amt=0 -> dout=%b", dout);

    // Reset in the middle of a rotation.
    @(negedge clk);
    start = 1'b1; din = 8'b11001010; dir = 1'b0; amt = AW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    $display("op abort din=11001010 dir=0 amt=5 -> reset, dout=%b", dout);
    do_op(8'b10010101, 1'b1, 3, 8'b10101100, "after_reset");

    // Randomised operations with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      rd = N'($urandom);
      rr = 1'($urandom);
      ra = int'($urandom_range(0, N - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(rd, rr, ra, restore(rd, rr, ra), "rand");
      chk("rand_roundtrip", 32'(rr ? rotr(dout, ra) : rotl(dout, ra)), 32'(rd));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rotate_restore_seq.md
# rotate_restore_seq

Sequential inverse of the rotate-by-one datapath: it accepts an N-bit word that has been rotated AMT places in direction DIR, and restores the original word. It rotates the opposite way, one bit per clock, under a start/busy/done handshake. It sits downstream of the rotate stage and recovers the original word. A multi-cycle bit-serial rotator is used here in place of a combinational barrel rotator.

## Interface
- N, default 8: data width in bits, N ≥ 2.
- AW, default $clog2(N): width of the rotate-amount field.

- CLK, input, 1: single clock; all state changes on the rising edge.
- N_RESET, input, 1: asynchronous, active-low reset.
- START, input, 1: request; sampled only in IDLE.
- DIN, input, N: rotated word; captured on the accepted START edge.
- DIR, input, 1: direction DIN was rotated (1 = right, 0 = left); captured with DIN.
- AMT, input, AW: number of places DIN was rotated (0..N-1); captured with DIN.
- BUSY, output, 1: high in LOAD-accepted/ROT states; low in IDLE and DONE.
- DONE, output, 1: one-cycle pulse; DOUT holds the restored word.
- DOUT, output, N: working/result register.

## Operation
- States are IDLE, ROT and DONE.
- **IDLE:**
  - START=1 at an edge loads DOUT←DIN, CNT←AMT and DIR_R←DIR.
  - Next state is ROT if AMT≠0, otherwise DONE.
  - START=0 holds IDLE.
- **ROT:**
  - Each edge rotates DOUT by one place opposite to DIR_R and decrements CNT.
    - DIR_R=1: DOUT←{DOUT[N-2:0],DOUT[N-1]} (rotate left).
    - DIR_R=0: DOUT←{DOUT[0],DOUT[N-1:1]} (rotate right).
  - On the edge where CNT=1 (the last rotation), next state is DONE.
- **DONE:** DONE=1 for exactly one cycle, and next state is IDLE unconditionally.
- **Result hold:** DOUT holds the result in DONE and IDLE until the next accepted START.
- **START outside IDLE:** ignored in ROT and DONE. It is not queued, and DIN/DIR/AMT changes have no effect.
- **Back-to-back:** a new START is accepted no earlier than the first IDLE cycle after DONE.
- **Width rules:**
  - CNT is AW bits and never underflows: the decrement occurs only in ROT with CNT ≥ 1.
  - AMT values ≥ N are not legal when N is not a power of two; behaviour then is defined only as AMT rotations.

## Timing
- **Reset (N_RESET low, asynchronous):** state=IDLE, DOUT=0, CNT=0, DIR_R=0, BUSY=0, DONE=0.
  - Asserting reset mid-operation aborts immediately.
  - The first START is accepted on the first edge after N_RESET deasserts.
- **Latency:** counting the START-sampling edge as edge 1, DONE is high after edge AMT+1.
  - AMT=0 gives DONE after edge 1.
  - AMT=N-1 gives DONE after edge N.
- **BUSY:** high from after edge 1 until the edge that enters DONE. It is low during the DONE cycle. For AMT=0, BUSY never rises.
- **DOUT during ROT:** shows intermediate rotations. DOUT is valid only when DONE=1 or afterwards in IDLE.
- **Outputs:** all outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- **Right, one place:** N=8, DIN=01010110, DIR=1, AMT=1, START pulse → DONE high after edge 2, DOUT=10101100, BUSY high only after edge 1.
- **Right, three places:** DIN=10010101, DIR=1, AMT=3 → DONE after edge 4, DOUT=10101100. Intermediate DOUT values are 00101011, then 01010110, then 10101100.
- **Left, two and seven places:**
  - DIN=10110010, DIR=0, AMT=2 → DOUT=10101100 after edge 3.
  - DIN=01010110, DIR=0, AMT=7 → DOUT=10101100 after edge 8.
- **Zero amount:** DIN=11110000, AMT=0 → DONE after edge 1, DOUT=11110000, BUSY stays 0.
- **START not in IDLE:** START held high throughout with DIN changed mid-ROT → the second operation starts only in IDLE after the DONE cycle. The first result is unaffected by the later DIN.
- **Reset mid-operation:** N_RESET pulsed low during ROT (AMT=5) → DOUT=0, BUSY=0 and DONE=0 immediately, with no DONE pulse. A subsequent START with DIN=10010101, DIR=1, AMT=3 yields 10101100.
